// File: rtl/apb_pkg.sv
// Shared APB definitions used by the APB initiator.
//   - bus address / data widths
//   - FSM state encodings (as localparams and as an enum type)
//   - address mask that forces word alignment
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = IDLE,
    ST_SETUP  = SETUP,
    ST_ACCESS = ACCESS
  } apb_state_e;

  // APB addresses are word aligned; the two low bits are always dropped.
  localparam logic [APB_ADDR_W-1:0] APB_ADDR_MASK = {{(APB_ADDR_W-2){1'b1}}, 2'b00};

endpackage

// File: rtl/apb_master.sv
// apb_master: single-outstanding APB3 initiator.
// Converts a valid/ready command port into SETUP/ACCESS transfers and returns
// read data and slave error on a one-cycle response strobe (no backpressure).
// Back-to-back commands go ACCESS -> SETUP with no idle cycle in between.
//
// Ports
//   clk, reset_n                 bus clock, async active-low reset
//   cmd_valid/cmd_ready          command handshake
//   cmd_write/cmd_addr/cmd_wdata command fields (cmd_addr[1:0] ignored)
//   rsp_valid/rsp_rdata/rsp_err  one-cycle response (rdata is 0 for writes)
//   m_*                          APB3 initiator signals
//
// Parameter
//   TIMEOUT  max ACCESS wait cycles before abort (1..65535); only active when
//            the macro APB_MASTER_TIMEOUT_EN is defined.
//
// State    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no transfer; ready for a command
// ST_SETUP | psel high, penable low; always one cycle
// ST_ACCESS| psel and penable high; wait for pready (or timeout)
module apb_master
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [APB_ADDR_W-1:0] cmd_addr,
  input  logic [APB_DATA_W-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [APB_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic [APB_ADDR_W-1:0] m_paddr,
  output logic                  m_pwrite,
  output logic                  m_psel,
  output logic                  m_penable,
  output logic [APB_DATA_W-1:0] m_pwdata,
  input  logic [APB_DATA_W-1:0] m_prdata,
  input  logic                  m_pready,
  input  logic                  m_pslverr
);

  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_timeout_range
    $error("apb_master: TIMEOUT out of range 1..65535");
  end

  apb_state_e            r_state;
  apb_state_e            w_state_nxt;
  logic [APB_ADDR_W-1:0] r_addr;
  logic                  r_write;
  logic [APB_DATA_W-1:0] r_wdata;
  logic                  r_rsp_valid;
  logic [APB_DATA_W-1:0] r_rsp_rdata;
  logic                  r_rsp_err;
  logic                  w_accept;
  logic                  w_complete;
  logic                  w_timeout;
  logic                  w_limit;

`ifdef APB_MASTER_TIMEOUT_EN
  logic [15:0] r_wait_cnt;

  // Cleared while in SETUP so every ACCESS phase starts counting from zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_SETUP) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_ACCESS && !m_pready) begin
      r_wait_cnt <= r_wait_cnt + 16'd1;
    end
  end

  assign w_limit = (r_wait_cnt == 16'(TIMEOUT));
`else
  assign w_limit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    cmd_ready   = 1'b0;
    m_psel      = 1'b0;
    m_penable   = 1'b0;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_SETUP;
        end
      end
      ST_SETUP: begin
        m_psel      = 1'b1;
        w_state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        m_psel    = 1'b1;
        m_penable = 1'b1;
        // A pready arriving in the limit cycle still completes normally.
        if (m_pready) begin
          w_complete = 1'b1;
          cmd_ready  = 1'b1;
          if (cmd_valid) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_SETUP;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end else if (w_limit) begin
          w_timeout   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_addr  <= cmd_addr & APB_ADDR_MASK;
      r_write <= cmd_write;
      r_wdata <= cmd_wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_rsp_valid <= w_complete | w_timeout;
      if (w_complete) begin
        r_rsp_rdata <= r_write ? '0 : m_prdata;
        r_rsp_err   <= m_pslverr;
      end else if (w_timeout) begin
        r_rsp_rdata <= '0;
        r_rsp_err   <= 1'b1;
      end
    end
  end

  assign m_paddr   = r_addr;
  assign m_pwrite  = r_write;
  assign m_pwdata  = r_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb_master.sv
// Self-checking bench for apb_master. A reactive APB slave and a command
// driver run cycle by cycle; expected response timing and data come from the
// transfer-level rule: a transfer with W wait states occupies 2+W bus cycles
// from acceptance, and its response appears one cycle after the last of them.
module tb_apb_master;

  localparam int TB_TIMEOUT = 8;
  localparam int LOGN = 256;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] m_paddr;
  logic        m_pwrite;
  logic        m_psel;
  logic        m_penable;
  logic [31:0] m_pwdata;
  logic [31:0] m_prdata = '0;
  logic        m_pready = 1'b0;
  logic        m_pslverr = 1'b0;

  always #5 clk = ~clk;

  apb_master #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .m_paddr(m_paddr), .m_pwrite(m_pwrite), .m_psel(m_psel), .m_penable(m_penable),
    .m_pwdata(m_pwdata), .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } txn_t;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  txn_t cmd_q[$];
  txn_t slv_q[$];
  int   acc_cyc[$];
  rsp_t rsp_q[$];

  int          cyc;
  int          wait_left;
  logic [31:0] cur_rdata;
  logic        cur_err;
  int          checks = 0;
  int          errors = 0;

  logic        psel_log  [LOGN];
  logic        pen_log   [LOGN];
  logic        pwrite_log[LOGN];
  logic        rv_log    [LOGN];
  logic [31:0] paddr_log [LOGN];
  logic [31:0] pwdata_log[LOGN];

  task automatic clear();
    cmd_q.delete(); slv_q.delete(); acc_cyc.delete(); rsp_q.delete();
    cyc = -1; wait_left = 0; cur_rdata = '0; cur_err = 1'b0;
    for (int i = 0; i < LOGN; i++) begin
      psel_log[i] = 1'b0; pen_log[i] = 1'b0; pwrite_log[i] = 1'b0; rv_log[i] = 1'b0;
      paddr_log[i] = '0; pwdata_log[i] = '0;
    end
  endtask

  // One bus cycle: drive command and slave inputs 1ns after the edge,
  // sample everything 1ns later.
  task automatic tick();
    txn_t t;
    @(posedge clk); #1;
    cyc++;
    cmd_valid = (cmd_q.size() != 0);
    if (cmd_valid) begin
      cmd_write = cmd_q[0].wr; cmd_addr = cmd_q[0].addr; cmd_wdata = cmd_q[0].wdata;
    end else begin
      cmd_write = 1'($urandom_range(0, 1)); cmd_addr = $urandom; cmd_wdata = $urandom;
    end
    if (m_psel && !m_penable && slv_q.size() != 0) begin
      t = slv_q.pop_front();
      wait_left = t.waits; cur_rdata = t.rdata; cur_err = t.err;
    end
    if (m_psel && m_penable) begin
      if (wait_left == 0) begin
        m_pready = 1'b1; m_prdata = cur_rdata; m_pslverr = cur_err;
      end else begin
        m_pready = 1'b0; m_prdata = $urandom; m_pslverr = 1'($urandom_range(0, 1));
        wait_left--;
      end
    end else begin
      m_pready = 1'($urandom_range(0, 1)); m_prdata = $urandom; m_pslverr = 1'($urandom_range(0, 1));
    end
    #1;
    if (cyc < LOGN) begin
      psel_log[cyc] = m_psel; pen_log[cyc] = m_penable; pwrite_log[cyc] = m_pwrite;
      rv_log[cyc] = rsp_valid; paddr_log[cyc] = m_paddr; pwdata_log[cyc] = m_pwdata;
    end
    if (rsp_valid) rsp_q.push_back('{cyc, rsp_rdata, rsp_err});
    if (cmd_valid && cmd_ready) begin
      t = cmd_q.pop_front();
      slv_q.push_back(t);
      acc_cyc.push_back(cyc);
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #12;
    checks++;
    if ({m_psel, m_penable, rsp_valid, rsp_err, m_pwrite} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl got %b exp 00000", {m_psel, m_penable, rsp_valid, rsp_err, m_pwrite});
    end
    checks++;
    if ({m_paddr, m_pwdata, rsp_rdata} !== 96'b0) begin
      errors++; $display("FAIL reset_data got %0h/%0h/%0h exp 0", m_paddr, m_pwdata, rsp_rdata);
    end
    @(negedge clk); reset_n = 1'b1; #1;
    checks++;
    if (cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_zero_wait_read();
    clear();
    cmd_q.push_back('{1'b0, 32'h0000_0404, 32'h0, 32'hDEAD_BEEF, 1'b0, 0});
    run(6);
    checks++;
    if (rsp_q.size() != 1) begin errors++; $display("FAIL zw_rsp_count got %0d exp 1", rsp_q.size()); end
    else begin
      checks++;
      if (rsp_q[0].cyc != 3) begin errors++; $display("FAIL zw_latency got %0d exp 3", rsp_q[0].cyc); end
      checks++;
      if (rsp_q[0].rdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL zw_rdata got %h exp deadbeef", rsp_q[0].rdata); end
      checks++;
      if (rsp_q[0].err !== 1'b0) begin errors++; $display("FAIL zw_err got %b exp 0", rsp_q[0].err); end
    end
    checks++;
    if (paddr_log[1] !== 32'h0000_0404) begin errors++; $display("FAIL zw_paddr got %h exp 00000404", paddr_log[1]); end
  endtask

  task automatic test_write_waits();
    clear();
    cmd_q.push_back('{1'b1, 32'h0000_0C07, 32'h1234_5678, 32'hFFFF_FFFF, 1'b0, 4});
    run(10);
    checks++;
    if (paddr_log[1] !== 32'h0000_0C04 || pwrite_log[1] !== 1'b1) begin
      errors++; $display("FAIL wr_setup got %h/%b exp 00000c04/1", paddr_log[1], pwrite_log[1]);
    end
    for (int c = 2; c <= 6; c++) begin
      checks++;
      if (!(psel_log[c] && pen_log[c]) || paddr_log[c] !== 32'h0000_0C04 ||
          pwrite_log[c] !== 1'b1 || pwdata_log[c] !== 32'h1234_5678) begin
        errors++;
        $display("FAIL wr_stable c%0d got %b%b %h %b %h exp 11 00000c04 1 12345678",
                 c, psel_log[c], pen_log[c], paddr_log[c], pwrite_log[c], pwdata_log[c]);
      end
    end
    checks++;
    if (rsp_q.size() != 1) begin errors++; $display("FAIL wr_rsp_count got %0d exp 1", rsp_q.size()); end
    else begin
      checks++;
      if (rsp_q[0].cyc != 7) begin errors++; $display("FAIL wr_latency got %0d exp 7", rsp_q[0].cyc); end
      checks++;
      if (rsp_q[0].err !== 1'b0 || rsp_q[0].rdata !== 32'h0) begin
        errors++; $display("FAIL wr_rsp got err %b rdata %h exp 0/0", rsp_q[0].err, rsp_q[0].rdata);
      end
    end
  endtask

  task automatic test_back_to_back();
    int exp_c[3] = '{3, 5, 7};
    clear();
    for (int i = 0; i < 3; i++)
      cmd_q.push_back('{1'b0, 32'h100 + 32'(i * 4), 32'h0, 32'hA000_0000 + 32'(i), 1'b0, 0});
    run(10);
    checks++;
    if (rsp_q.size() != 3) begin errors++; $display("FAIL b2b_count got %0d exp 3", rsp_q.size()); end
    for (int i = 0; i < 3 && i < rsp_q.size(); i++) begin
      checks++;
      if (rsp_q[i].cyc != exp_c[i] || rsp_q[i].rdata !== 32'hA000_0000 + 32'(i)) begin
        errors++; $display("FAIL b2b_rsp%0d got c%0d %h exp c%0d %h", i, rsp_q[i].cyc, rsp_q[i].rdata,
                           exp_c[i], 32'hA000_0000 + 32'(i));
      end
    end
    for (int c = 1; c <= 7; c++) begin
      checks++;
      if (psel_log[c] !== (c <= 6) || pen_log[c] !== (c <= 6 && c % 2 == 0)) begin
        errors++; $display("FAIL b2b_bus c%0d got psel %b pen %b exp %b %b", c, psel_log[c], pen_log[c],
                           c <= 6, c <= 6 && c % 2 == 0);
      end
    end
  endtask

  task automatic test_slave_error();
    clear();
    cmd_q.push_back('{1'b0, 32'h0000_2000, 32'h0, 32'h5555_AAAA, 1'b1, 1});
    run(8);
    checks++;
    if (rsp_q.size() != 1) begin errors++; $display("FAIL err_count got %0d exp 1", rsp_q.size()); end
    else begin
      checks++;
      if (rsp_q[0].err !== 1'b1 || rsp_q[0].cyc != 4) begin
        errors++; $display("FAIL err_rsp got err %b c%0d exp 1 c4", rsp_q[0].err, rsp_q[0].cyc);
      end
      checks++;
      if (rv_log[5] !== 1'b0) begin errors++; $display("FAIL err_pulse_width got %b exp 0", rv_log[5]); end
    end
  endtask

  task automatic test_reset_mid();
    clear();
    cmd_q.push_back('{1'b1, 32'h0000_3004, 32'hCAFE_F00D, 32'h0, 1'b0, 20});
    run(5);
    #1 reset_n = 1'b0;
    #1;
    checks++;
    if (m_psel !== 1'b0 || m_penable !== 1'b0 || rsp_valid !== 1'b0 || m_paddr !== 32'h0) begin
      errors++; $display("FAIL rstmid_async got %b%b%b %h exp 000 0", m_psel, m_penable, rsp_valid, m_paddr);
    end
    @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
    clear();
    run(4);
    checks++;
    if (rsp_q.size() != 0 || psel_log[0] || psel_log[3]) begin
      errors++; $display("FAIL rstmid_quiet got rsp %0d psel %b exp 0 0", rsp_q.size(), psel_log[3]);
    end
    clear();
    cmd_q.push_back('{1'b0, 32'h0000_3008, 32'h0, 32'h0BAD_CAFE, 1'b0, 0});
    run(6);
    checks++;
    if (rsp_q.size() != 1 || rsp_q[0].cyc != 3 || rsp_q[0].rdata !== 32'h0BAD_CAFE) begin
      errors++; $display("FAIL rstmid_next got %0d rsp exp 1 at c3 with 0badcafe", rsp_q.size());
    end
  endtask

  task automatic test_random();
    for (int b = 0; b < 12; b++) begin
      txn_t ts[$];
      int   exp_acc[$];
      int   exp_rsp[$];
      int   n;
      int   a;
      clear();
      n = $urandom_range(1, 3);
      a = 0;
      for (int i = 0; i < n; i++) begin
        txn_t t;
        t.wr = 1'($urandom_range(0, 1)); t.addr = $urandom; t.wdata = $urandom;
        t.rdata = $urandom; t.err = 1'($urandom_range(0, 1)); t.waits = $urandom_range(0, 3);
        ts.push_back(t); cmd_q.push_back(t);
        exp_acc.push_back(a);
        exp_rsp.push_back(a + 3 + t.waits);
        a = a + 2 + t.waits;
      end
      run(a + 3);
      checks++;
      if (rsp_q.size() != n || acc_cyc.size() != n) begin
        errors++; $display("FAIL rnd%0d_count got rsp %0d acc %0d exp %0d", b, rsp_q.size(), acc_cyc.size(), n);
      end
      for (int i = 0; i < n && i < rsp_q.size() && i < acc_cyc.size(); i++) begin
        logic [31:0] exp_rd;
        exp_rd = ts[i].wr ? 32'h0 : ts[i].rdata;
        checks++;
        if (acc_cyc[i] != exp_acc[i] || rsp_q[i].cyc != exp_rsp[i]) begin
          errors++; $display("FAIL rnd%0d_timing%0d got acc %0d rsp %0d exp %0d %0d", b, i,
                             acc_cyc[i], rsp_q[i].cyc, exp_acc[i], exp_rsp[i]);
        end
        checks++;
        if (rsp_q[i].rdata !== exp_rd || rsp_q[i].err !== ts[i].err) begin
          errors++; $display("FAIL rnd%0d_data%0d got %h/%b exp %h/%b", b, i, rsp_q[i].rdata,
                             rsp_q[i].err, exp_rd, ts[i].err);
        end
        checks++;
        if (paddr_log[exp_acc[i] + 1] !== {ts[i].addr[31:2], 2'b00} ||
            pwrite_log[exp_acc[i] + 1] !== ts[i].wr || pwdata_log[exp_acc[i] + 1] !== ts[i].wdata) begin
          errors++; $display("FAIL rnd%0d_bus%0d got %h/%b/%h exp %h/%b/%h", b, i,
                             paddr_log[exp_acc[i] + 1], pwrite_log[exp_acc[i] + 1], pwdata_log[exp_acc[i] + 1],
                             {ts[i].addr[31:2], 2'b00}, ts[i].wr, ts[i].wdata);
        end
      end
    end
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  // TIMEOUT counted wait cycles, then one limit cycle, then psel drops and
  // the error response appears; a waiting command is accepted only after that.
  task automatic test_timeout();
    int t_rsp;
    t_rsp = 3 + TB_TIMEOUT;
    clear();
    cmd_q.push_back('{1'b0, 32'h0000_4000, 32'h0, 32'h1111_1111, 1'b0, 1000});
    cmd_q.push_back('{1'b1, 32'h0000_4004, 32'h2222_2222, 32'h0, 1'b0, 1000});
    run(2 * t_rsp + 4);
    checks++;
    if (psel_log[t_rsp - 1] !== 1'b1 || psel_log[t_rsp] !== 1'b0) begin
      errors++; $display("FAIL to_psel_drop got %b%b exp 10", psel_log[t_rsp - 1], psel_log[t_rsp]);
    end
    checks++;
    if (rsp_q.size() != 2) begin errors++; $display("FAIL to_count got %0d exp 2", rsp_q.size()); end
    else begin
      checks++;
      if (rsp_q[0].cyc != t_rsp || rsp_q[0].err !== 1'b1 || rsp_q[0].rdata !== 32'h0) begin
        errors++; $display("FAIL to_rsp got c%0d %b %h exp c%0d 1 0", rsp_q[0].cyc, rsp_q[0].err,
                           rsp_q[0].rdata, t_rsp);
      end
    end
    checks++;
    if (acc_cyc.size() != 2 || acc_cyc[1] != t_rsp) begin
      errors++; $display("FAIL to_no_accept got %0d accepts exp 2nd at c%0d", acc_cyc.size(), t_rsp);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_zero_wait_read();
    test_write_waits();
    test_back_to_back();
    test_slave_error();
    test_reset_mid();
    test_random();
`ifdef APB_MASTER_TIMEOUT_EN
    test_timeout();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
